// File: rtl/alu_wb_stage_pkg.sv
// Shared types and constants for the ALU execute/writeback stage:
// FSM state encoding, flag bit positions and the default multi-cycle wait.
package alu_wb_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MCP_WAIT = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_W = 3;

  localparam int MCP_CYCLES_DEFAULT = 2;

  // Z is stored as the inverse of the ALU's result-nonzero output.
  function automatic logic [FLAG_W-1:0] alu_flags(input logic cout,
                                                  input logic vout,
                                                  input logic qnz);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_C] = cout;
    f[FLAG_V] = vout;
    f[FLAG_Z] = ~qnz;
    return f;
  endfunction

endpackage

// File: rtl/alu_wb_stage.sv
// Execute/writeback stage: registers ALU result and C/V/Z flags for the register-file
// write port. Multi-cycle stall support is built only when ALU_MCP_STALL_EN is defined.
module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int MCP_CYCLES = MCP_CYCLES_DEFAULT,
  parameter int RF_AW      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      alu_dout,
  input  logic             alu_cout,
  input  logic             alu_vout,
  input  logic             alu_qnz,
  input  logic             alu_mcp,
  input  logic             rf_we_in,
  input  logic             flag_we_in,
  input  logic [RF_AW-1:0] rf_waddr_in,
  output logic             rf_we,
  input  logic             rf_ready,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z
);

  state_t             state_q, state_d;
  logic               capture;
  logic               mcp_load;
  logic               mcp_req;
  logic               mcp_done;
  logic [31:0]        wdata_q;
  logic [RF_AW-1:0]   waddr_q;
  logic [FLAG_W-1:0]  flags_q;

`ifdef ALU_MCP_STALL_EN
  localparam int MCP_CW = 3;

  logic [MCP_CW-1:0] cnt_q, cnt_d;

  assign mcp_req  = alu_mcp;
  // A count of 0 is treated like 1 so the wait can never lock up.
  assign mcp_done = (cnt_q <= MCP_CW'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (mcp_load) begin
      cnt_d = MCP_CW'(MCP_CYCLES);
    end else if (state_q == ST_MCP_WAIT) begin
      cnt_d = mcp_done ? '0 : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_mcp;

  assign mcp_req    = 1'b0;
  assign mcp_done   = 1'b1;
  assign unused_mcp = alu_mcp ^ mcp_load ^ (MCP_CYCLES != 0);
`endif

  // MCP_WAIT ignores in_valid: upstream holds the same instruction until capture.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    capture  = 1'b0;
    mcp_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (mcp_req) begin
            mcp_load = 1'b1;
            state_d  = ST_MCP_WAIT;
          end else begin
            capture = 1'b1;
            state_d = rf_we_in ? ST_HOLD : ST_IDLE;
          end
        end
      end
      ST_MCP_WAIT: begin
        if (mcp_done) begin
          in_ready = 1'b1;
          capture  = 1'b1;
          state_d  = rf_we_in ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        in_ready = rf_ready;
        if (rf_ready) begin
          if (in_valid && mcp_req) begin
            mcp_load = 1'b1;
            state_d  = ST_MCP_WAIT;
          end else if (in_valid) begin
            capture = 1'b1;
            state_d = rf_we_in ? ST_HOLD : ST_IDLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wdata_q <= '0;
      waddr_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture && rf_we_in) begin
        wdata_q <= alu_dout;
        waddr_q <= rf_waddr_in;
      end
      if (capture && flag_we_in) begin
        flags_q <= alu_flags(alu_cout, alu_vout, alu_qnz);
      end
    end
  end

  assign rf_we    = (state_q == ST_HOLD);
  assign rf_wdata = wdata_q;
  assign rf_waddr = waddr_q;
  assign flag_c   = flags_q[FLAG_C];
  assign flag_v   = flags_q[FLAG_V];
  assign flag_z   = flags_q[FLAG_Z];

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage; the expected write port and flag state is kept
// as plain architectural variables updated per committed instruction.
module tb_alu_wb_stage;

  localparam int MCP = 2;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   alu_dout;
  logic          alu_cout, alu_vout, alu_qnz, alu_mcp;
  logic          rf_we_in, flag_we_in;
  logic [AW-1:0] rf_waddr_in;
  logic          rf_we;
  logic          rf_ready;
  logic [AW-1:0] rf_waddr;
  logic [31:0]   rf_wdata;
  logic          flag_c, flag_v, flag_z;

  int passed = 0;
  int total  = 0;

  logic          exp_we;
  logic [AW-1:0] exp_waddr;
  logic [31:0]   exp_wdata;
  logic [2:0]    exp_flags;

  typedef struct packed {
    logic [31:0]   dout;
    logic          cout;
    logic          vout;
    logic          qnz;
    logic          mcp;
    logic          we;
    logic          fwe;
    logic [AW-1:0] waddr;
  } op_t;

  alu_wb_stage #(.MCP_CYCLES(MCP), .RF_AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_dout(alu_dout), .alu_cout(alu_cout), .alu_vout(alu_vout), .alu_qnz(alu_qnz),
    .alu_mcp(alu_mcp), .rf_we_in(rf_we_in), .flag_we_in(flag_we_in),
    .rf_waddr_in(rf_waddr_in), .rf_we(rf_we), .rf_ready(rf_ready),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] obs();
    return {rf_we, rf_waddr, rf_wdata, flag_c, flag_v, flag_z};
  endfunction

  function automatic logic [39:0] expv();
    return {exp_we, exp_waddr, exp_wdata, exp_flags};
  endfunction

  function automatic op_t rand_op();
    op_t         o;
    logic [31:0] r;
    r       = $urandom();
    o.dout  = $urandom();
    o.cout  = r[0];
    o.vout  = r[1];
    o.qnz   = r[2];
    o.we    = r[3];
    o.fwe   = r[4];
    o.waddr = r[11:8];
`ifdef ALU_MCP_STALL_EN
    o.mcp   = 1'b0;
`else
    o.mcp   = r[5];
`endif
    return o;
  endfunction

  task automatic apply(input op_t o);
    in_valid    = 1'b1;
    alu_dout    = o.dout;
    alu_cout    = o.cout;
    alu_vout    = o.vout;
    alu_qnz     = o.qnz;
    alu_mcp     = o.mcp;
    rf_we_in    = o.we;
    flag_we_in  = o.fwe;
    rf_waddr_in = o.waddr;
  endtask

  task automatic idle_inputs();
    op_t o;
    o = rand_op();
    apply(o);
    in_valid = 1'b0;
    alu_mcp  = 1'b0;
  endtask

  // Architectural effect of one instruction reaching the write port with rf_ready high.
  task automatic model_commit(input op_t o);
    exp_we = o.we;
    if (o.we) begin
      exp_wdata = o.dout;
      exp_waddr = o.waddr;
    end
    if (o.fwe) exp_flags = {o.cout, o.vout, ~o.qnz};
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    rf_ready = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b0;
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_flags = '0;
    total++;
    if (obs() !== expv()) $display("FAIL reset_state: got %h expected %h", obs(), expv());
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else passed++;
  endtask

  task automatic test_add();
    op_t o;
    o = '{dout: 32'h0000_0005, cout: 1'b0, vout: 1'b0, qnz: 1'b1, mcp: 1'b0,
          we: 1'b1, fwe: 1'b1, waddr: 4'd3};
    apply(o);
    @(posedge clk); #1;
    model_commit(o);
    idle_inputs();
    total++;
    if (obs() !== expv()) $display("FAIL add_result: got %h expected %h", obs(), expv());
    else passed++;
    @(posedge clk); #1;
    exp_we = 1'b0;
    total++;
    if (obs() !== expv()) $display("FAIL add_drain: got %h expected %h", obs(), expv());
    else passed++;
  endtask

  task automatic test_cmp();
    op_t o;
    o      = rand_op();
    o.qnz  = 1'b0;
    o.cout = 1'b1;
    o.we   = 1'b0;
    o.fwe  = 1'b1;
    o.mcp  = 1'b0;
    apply(o);
    @(posedge clk); #1;
    model_commit(o);
    idle_inputs();
    total++;
    if (obs() !== expv() || flag_z !== 1'b1 || flag_c !== 1'b1)
      $display("FAIL cmp_flags: got %h expected %h", obs(), expv());
    else passed++;
  endtask

  task automatic test_back_to_back();
    op_t o;
    rf_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      o = rand_op();
      apply(o);
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b expected 1", n, in_ready);
      else passed++;
      @(posedge clk); #1;
      model_commit(o);
      total++;
      if (obs() !== expv()) $display("FAIL b2b_result[%0d]: got %h expected %h", n, obs(), expv());
      else passed++;
    end
    idle_inputs();
    @(posedge clk); #1;
    exp_we = 1'b0;
    total++;
    if (obs() !== expv()) $display("FAIL b2b_tail: got %h expected %h", obs(), expv());
    else passed++;
  endtask

  task automatic test_mcp();
    op_t o;
    rf_ready = 1'b1;
`ifdef ALU_MCP_STALL_EN
    for (int n = 0; n < 4; n++) begin
      o     = rand_op();
      o.mcp = 1'b1;
      if (n == 0) begin
        o.dout = 32'h1234_5678;
        o.we   = 1'b1;
        o.fwe  = 1'b1;
      end
      apply(o);
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL mcp_accept_ready[%0d]: got %b expected 1", n, in_ready);
      else passed++;
      @(posedge clk); #1;
      exp_we = 1'b0;
      for (int k = 1; k < MCP; k++) begin
        total++;
        if (in_ready !== 1'b0 || obs() !== expv())
          $display("FAIL mcp_wait[%0d]: got ready %b out %h expected ready 0 out %h",
                   n, in_ready, obs(), expv());
        else passed++;
        @(posedge clk); #1;
      end
      total++;
      if (in_ready !== 1'b1 || obs() !== expv())
        $display("FAIL mcp_capture_cycle[%0d]: got ready %b out %h expected ready 1 out %h",
                 n, in_ready, obs(), expv());
      else passed++;
      @(posedge clk); #1;
      model_commit(o);
      total++;
      if (obs() !== expv()) $display("FAIL mcp_result[%0d]: got %h expected %h", n, obs(), expv());
      else passed++;
    end
`else
    for (int n = 0; n < 4; n++) begin
      o     = rand_op();
      o.mcp = 1'b1;
      apply(o);
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL nomcp_ready[%0d]: got %b expected 1", n, in_ready);
      else passed++;
      @(posedge clk); #1;
      model_commit(o);
      total++;
      if (obs() !== expv()) $display("FAIL nomcp_result[%0d]: got %h expected %h", n, obs(), expv());
      else passed++;
    end
`endif
    idle_inputs();
    @(posedge clk); #1;
    exp_we = 1'b0;
    total++;
    if (obs() !== expv()) $display("FAIL mcp_tail: got %h expected %h", obs(), expv());
    else passed++;
  endtask

  task automatic test_backpressure();
    op_t a, b;
    rf_ready = 1'b1;
    a     = rand_op();
    a.we  = 1'b1;
    a.mcp = 1'b0;
    apply(a);
    @(posedge clk); #1;
    model_commit(a);
    rf_ready = 1'b0;
    b     = rand_op();
    b.we  = 1'b1;
    b.fwe = 1'b1;
    b.mcp = 1'b0;
    b.cout = ~exp_flags[2];
    apply(b);
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (in_ready !== 1'b0 || obs() !== expv())
        $display("FAIL stall[%0d]: got ready %b out %h expected ready 0 out %h",
                 k, in_ready, obs(), expv());
      else passed++;
      @(posedge clk); #1;
    end
    rf_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL release_ready: got %b expected 1", in_ready);
    else passed++;
    @(posedge clk); #1;
    model_commit(b);
    idle_inputs();
    total++;
    if (obs() !== expv()) $display("FAIL release_capture: got %h expected %h", obs(), expv());
    else passed++;
    @(posedge clk); #1;
    exp_we = 1'b0;
    total++;
    if (obs() !== expv()) $display("FAIL release_drain: got %h expected %h", obs(), expv());
    else passed++;
  endtask

  task automatic test_reset_mid();
    op_t o;
    rf_ready = 1'b1;
    o     = rand_op();
    o.we  = 1'b1;
    o.fwe = 1'b1;
    o.qnz = 1'b0;
    o.mcp = 1'b0;
    apply(o);
    @(posedge clk); #1;
    model_commit(o);
    total++;
    if (obs() !== expv()) $display("FAIL pre_reset: got %h expected %h", obs(), expv());
    else passed++;
    o = rand_op();
`ifdef ALU_MCP_STALL_EN
    o.mcp = 1'b1;
`else
    rf_ready = 1'b0;
`endif
    apply(o);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rf_ready = 1'b1;
    idle_inputs();
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_flags = '0;
    total++;
    if (obs() !== expv() || in_ready !== 1'b1)
      $display("FAIL mid_reset: got ready %b out %h expected ready 1 out %h",
               in_ready, obs(), expv());
    else passed++;
    @(posedge clk); #1;
    total++;
    if (obs() !== expv()) $display("FAIL mid_reset_discard: got %h expected %h", obs(), expv());
    else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_back_to_back();
    test_mcp();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
